// File: rtl/hzdctl_pkg.sv
// Shared definitions for the Decode-stage hazard controller: instruction codes,
// tUse codes, stall-cause encodings and the in-flight writer slot record.
package hzd_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'o00;
  localparam logic [2:0] OPG_BRANCH = 3'o0;
  localparam logic [2:0] OPG_IMM    = 3'o1;
  localparam logic [2:0] OPG_LOAD   = 3'o4;
  localparam logic [2:0] OPG_STORE  = 3'o5;

  localparam logic [5:0] FN_JR      = 6'o10;
  localparam logic [5:0] FN_SYSCALL = 6'o14;
  localparam logic [5:0] FN_MFHI    = 6'o20;
  localparam logic [5:0] FN_MTHI    = 6'o21;
  localparam logic [5:0] FN_MFLO    = 6'o22;
  localparam logic [5:0] FN_MTLO    = 6'o23;
  localparam logic [5:0] FN_MULT    = 6'o30;
  localparam logic [5:0] FN_MULTU   = 6'o31;
  localparam logic [5:0] FN_DIV     = 6'o32;
  localparam logic [5:0] FN_DIVU    = 6'o33;

  localparam logic [1:0] TUSE_0 = 2'd0;
  localparam logic [1:0] TUSE_1 = 2'd1;

  localparam int MD_CNT_W = 5;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_DATA = 2'd1,
    CAUSE_MD   = 2'd2,
    CAUSE_BOTH = 2'd3
  } stall_cause_e;

  typedef enum logic [3:0] {
    CLS_RTYPE, CLS_JR, CLS_BRANCH, CLS_IMM, CLS_LOAD, CLS_STORE,
    CLS_MDTR, CLS_MDMT, CLS_MDMF, CLS_SYSCALL, CLS_OTHER
  } instr_class_e;

  typedef struct packed {
    logic       wen;
    logic [4:0] wreg;
    logic [1:0] tnew;
  } slot_t;

  function automatic instr_class_e decode_class(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_RTYPE) begin
      if (fn == FN_JR)                   return CLS_JR;
      if (fn == FN_SYSCALL)              return CLS_SYSCALL;
      if (fn == FN_MFHI || fn == FN_MFLO) return CLS_MDMF;
      if (fn == FN_MTHI || fn == FN_MTLO) return CLS_MDMT;
      if (fn[5:3] == FN_MULT[5:3])       return CLS_MDTR;
      return CLS_RTYPE;
    end
    if (op[5:3] == OPG_BRANCH && op[2]) return CLS_BRANCH;
    if (op[5:3] == OPG_IMM)             return CLS_IMM;
    if (op[5:3] == OPG_LOAD)            return CLS_LOAD;
    if (op[5:3] == OPG_STORE)           return CLS_STORE;
    return CLS_OTHER;
  endfunction

  function automatic logic is_div_funct(input logic [5:0] fn);
    return (fn == FN_DIV || fn == FN_DIVU) && !(fn == FN_MULT || fn == FN_MULTU);
  endfunction

  // A writer to $0 never produces a result anyone waits for.
  function automatic logic slot_hit(input slot_t s, input logic [4:0] src, input logic [1:0] tuse);
    return s.wen && (s.wreg != 5'd0) && (s.wreg == src) && (s.tnew > tuse);
  endfunction

  function automatic slot_t slot_age(input slot_t s);
    slot_t r;
    r      = s;
    r.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/hzdctl_if.sv
// D-stage instruction fields in, stall decision out.
interface hzdctl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       d_wen;
  logic [4:0] d_wreg;
  logic [1:0] d_tnew;
  logic       flush;
  logic       stall;
  logic [1:0] stall_cause;
  logic       md_busy;

  modport master (
    output opcode, funct, rs, rt, d_wen, d_wreg, d_tnew, flush,
    input  stall, stall_cause, md_busy
  );

  modport slave (
    input  opcode, funct, rs, rt, d_wen, d_wreg, d_tnew, flush,
    output stall, stall_cause, md_busy
  );
endinterface

// File: rtl/hzdctl_mdbusy.sv
// Multiply/divide occupancy counter: loads the op latency on issue, then
// counts down; busy while nonzero. Flush never reaches it.
module mdbusy
  import hzd_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  input  logic is_div,
  output logic busy
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYC);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYC);

  logic [MD_CNT_W-1:0] count;

  // NOTE: sequential state is always assigned with <= so every register samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset)              count <= '0;
    else if (issue)         count <= is_div ? DIV_LOAD : MULT_LOAD;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hzdctl.sv
// Decode-stage hazard controller: scoreboard of in-flight GRF writers with
// per-slot decrementing Tnew, plus the M/D busy stall.
module hzdctl
  import hzd_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input logic     clk,
  input logic     reset,
  hzdctl_if.slave bus
);

  slot_t        slots [DEPTH];
  instr_class_e cls;
  logic [1:0]   tuse;
  logic         use_rs, use_rt;
  logic         hit_rs, hit_rt;
  logic         data_stall, md_stall, stall, issue, md_busy;
  stall_cause_e cause;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    cls    = decode_class(bus.opcode, bus.funct);
    tuse   = (cls == CLS_JR || cls == CLS_BRANCH) ? TUSE_0 : TUSE_1;
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (cls)
      CLS_JR, CLS_IMM, CLS_LOAD, CLS_STORE, CLS_MDMT: use_rs = 1'b1;
      CLS_BRANCH, CLS_RTYPE, CLS_MDTR: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_hit(slots[k], bus.rs, tuse)) hit_rs = 1'b1;
      if (slot_hit(slots[k], bus.rt, tuse)) hit_rt = 1'b1;
    end
  end

  assign data_stall = (use_rs & hit_rs) | (use_rt & hit_rt);
  assign md_stall   = md_busy & (cls == CLS_MDTR || cls == CLS_MDMT || cls == CLS_MDMF);
  assign stall      = data_stall | md_stall;
  assign issue      = ~stall & ~bus.flush;
  assign cause      = stall_cause_e'({md_stall, data_stall});

  // NOTE: the slots are a handful of flops read by the hit logic from the very
  // first cycle, so they are reset rather than left as uninitialised storage.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      for (int k = 0; k < DEPTH; k++) slots[k] <= '0;
    end else begin
      slots[0] <= issue ? slot_t'{wen: bus.d_wen, wreg: bus.d_wreg, tnew: bus.d_tnew} : '0;
      for (int k = 1; k < DEPTH; k++) slots[k] <= slot_age(slots[k-1]);
    end
  end

  mdbusy #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_mdbusy (
    .clk    (clk),
    .reset  (reset),
    .issue  (issue && cls == CLS_MDTR),
    .is_div (is_div_funct(bus.funct)),
    .busy   (md_busy)
  );

  assign bus.stall       = stall;
  assign bus.stall_cause = cause;
  assign bus.md_busy     = md_busy;

endmodule

// File: tb/tb_hzdctl.sv
// Self-checking bench for hzdctl: directed hazard scenarios with literal stall
// counts, then randomized traffic against a writer-list reference model.
module tb_hzdctl;

  localparam int DEPTH    = 2;
  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hzdctl_if bus ();

  hzdctl #(
    .DEPTH    (DEPTH),
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: list of issued writers by cycle -------------
  typedef struct {
    int         issue_cyc;
    logic [4:0] wreg;
    int         tnew;
  } writer_t;

  writer_t wq[$];
  int      md_last  = -1000;
  int      cyc      = 0;
  bit      model_on = 0;

  function automatic void spec_decode(input logic [5:0] op, input logic [5:0] fn,
                                      output bit use_rs, output bit use_rt, output int tuse,
                                      output bit md_user, output bit mdtr, output bit is_div);
    bit r;
    r = (op == 6'o00);
    use_rs = 0; use_rt = 0; tuse = 1; md_user = 0; mdtr = 0; is_div = 0;
    if (r && fn == 6'o10) begin
      use_rs = 1; tuse = 0;
    end else if (op[5:3] == 3'o0 && op[2]) begin
      use_rs = 1; use_rt = 1; tuse = 0;
    end else if (r) begin
      mdtr    = (fn[5:3] == 3'o3);
      md_user = mdtr || fn == 6'o20 || fn == 6'o21 || fn == 6'o22 || fn == 6'o23;
      is_div  = (fn == 6'o32 || fn == 6'o33);
      if (fn == 6'o21 || fn == 6'o23) use_rs = 1;
      else if (!(fn == 6'o20 || fn == 6'o22 || fn == 6'o14)) begin
        use_rs = 1; use_rt = 1;
      end
    end else if (op[5:3] == 3'o1 || op[5:3] == 3'o4 || op[5:3] == 3'o5) begin
      use_rs = 1;
    end
  endfunction

  initial begin
    logic [5:0] s_op, s_fn;
    logic [4:0] s_rs, s_rt, s_wreg;
    logic [1:0] s_tnew;
    logic       s_wen, s_flush, s_reset;
    bit         u_rs, u_rt, md_user, mdtr, is_div, e_data, e_md, e_busy;
    int         tuse;
    forever begin
      @(negedge clk);
      s_op = bus.opcode; s_fn = bus.funct; s_rs = bus.rs; s_rt = bus.rt;
      s_wen = bus.d_wen; s_wreg = bus.d_wreg; s_tnew = bus.d_tnew;
      s_flush = bus.flush; s_reset = reset;
      spec_decode(s_op, s_fn, u_rs, u_rt, tuse, md_user, mdtr, is_div);
      e_data = 0;
      foreach (wq[i]) begin
        int age, tn;
        age = cyc - wq[i].issue_cyc - 1;
        tn  = wq[i].tnew - age;
        if (tn < 0) tn = 0;
        if (age < DEPTH && wq[i].wreg != 5'd0 && tn > tuse) begin
          if (u_rs && wq[i].wreg == s_rs) e_data = 1;
          if (u_rt && wq[i].wreg == s_rt) e_data = 1;
        end
      end
      e_busy = (cyc <= md_last);
      e_md   = e_busy && md_user;
      if (model_on && !s_reset) begin
        check("model_stall", {31'd0, bus.stall}, {31'd0, e_data | e_md});
        check("model_cause", {30'd0, bus.stall_cause}, {30'd0, e_md, e_data});
        check("model_md_busy", {31'd0, bus.md_busy}, {31'd0, e_busy});
      end
      @(posedge clk);
      if (s_reset) begin
        wq.delete();
        md_last  = -1000;
        model_on = 1;
      end else if (s_flush) begin
        wq.delete();
      end else if (!(e_data || e_md)) begin
        if (s_wen) wq.push_back('{cyc, s_wreg, int'(s_tnew)});
        if (mdtr) md_last = cyc + (is_div ? DIV_CYC : MULT_CYC);
      end
      for (int i = wq.size() - 1; i >= 0; i--)
        if (cyc - wq[i].issue_cyc >= DEPTH) wq.delete(i);
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                           input logic [4:0] rt, input logic wen, input logic [4:0] wreg,
                           input logic [1:0] tnew);
    bus.opcode = op; bus.funct = fn; bus.rs = rs; bus.rt = rt;
    bus.d_wen = wen; bus.d_wreg = wreg; bus.d_tnew = tnew;
  endtask

  task automatic set_nop();
    set_instr(6'o00, 6'o00, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0);
    bus.flush = 1'b0;
  endtask

  task automatic idle(input int n);
    set_nop();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the current D instruction until it issues; report stall count and cause.
  task automatic run_issue(input string name, input int exp_stalls, input int exp_cause);
    int n, cause;
    bit done;
    n = 0; cause = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.stall) begin
        if (n == 0) cause = int'(bus.stall_cause);
        n++;
      end else done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) n = -1;
    check(name, n, exp_stalls);
    if (exp_stalls > 0) check({name, "_cause"}, cause, exp_cause);
    set_nop();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit done;
    logic [5:0] ops [12];
    logic [5:0] fns [14];
    ops = '{6'o00, 6'o00, 6'o00, 6'o04, 6'o05, 6'o11, 6'o15, 6'o43, 6'o53, 6'o03, 6'o02, 6'o20};
    fns = '{6'o41, 6'o43, 6'o10, 6'o14, 6'o20, 6'o21, 6'o22, 6'o23,
            6'o30, 6'o31, 6'o32, 6'o33, 6'o00, 6'o52};

    reset = 1'b1;
    set_nop();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    check("reset_cause", {30'd0, bus.stall_cause}, 32'd0);
    check("reset_md_busy", {31'd0, bus.md_busy}, 32'd0);
    @(posedge clk); #1;

    // lw $1 then addu $2,$1,$3
    set_instr(6'o43, 6'o00, 5'd4, 5'd1, 1'b1, 5'd1, 2'd2); run_issue("lw1", 0, 0);
    set_instr(6'o00, 6'o41, 5'd1, 5'd3, 1'b1, 5'd2, 2'd1); run_issue("addu_after_lw", 1, 1);
    idle(3);

    // lw $1 then beq $1,$4
    set_instr(6'o43, 6'o00, 5'd4, 5'd1, 1'b1, 5'd1, 2'd2); run_issue("lw1_b", 0, 0);
    set_instr(6'o04, 6'o00, 5'd1, 5'd4, 1'b0, 5'd0, 2'd0); run_issue("beq_after_lw", 2, 1);
    idle(3);

    // addu $1 then beq $1
    set_instr(6'o00, 6'o41, 5'd2, 5'd3, 1'b1, 5'd1, 2'd1); run_issue("alu1", 0, 0);
    set_instr(6'o04, 6'o00, 5'd1, 5'd4, 1'b0, 5'd0, 2'd0); run_issue("beq_after_alu", 1, 1);
    idle(3);

    // jal then jr $31
    set_instr(6'o03, 6'o00, 5'd0, 5'd0, 1'b1, 5'd31, 2'd0); run_issue("jal", 0, 0);
    set_instr(6'o00, 6'o10, 5'd31, 5'd0, 1'b0, 5'd0, 2'd0); run_issue("jr_after_jal", 0, 0);
    idle(3);

    // mult then mflo; div then mfhi
    set_instr(6'o00, 6'o30, 5'd1, 5'd2, 1'b0, 5'd0, 2'd0); run_issue("mult", 0, 0);
    set_instr(6'o00, 6'o22, 5'd0, 5'd0, 1'b1, 5'd3, 2'd1); run_issue("mflo_after_mult", 5, 2);
    idle(3);
    set_instr(6'o00, 6'o32, 5'd1, 5'd2, 1'b0, 5'd0, 2'd0); run_issue("div", 0, 0);
    set_instr(6'o00, 6'o20, 5'd0, 5'd0, 1'b1, 5'd3, 2'd1); run_issue("mfhi_after_div", 10, 2);
    idle(3);

    // $0 writer, and a recorded non-writer
    set_instr(6'o43, 6'o00, 5'd4, 5'd0, 1'b1, 5'd0, 2'd2); run_issue("lw0", 0, 0);
    set_instr(6'o00, 6'o41, 5'd0, 5'd0, 1'b1, 5'd2, 2'd1); run_issue("addu_zero_src", 0, 0);
    idle(3);
    set_instr(6'o43, 6'o00, 5'd4, 5'd6, 1'b0, 5'd6, 2'd2); run_issue("lw6_nowen", 0, 0);
    set_instr(6'o00, 6'o41, 5'd6, 5'd7, 1'b1, 5'd5, 2'd1); run_issue("addu_nowen", 0, 0);
    idle(3);

    // flush kills the lw in slot 0
    set_instr(6'o43, 6'o00, 5'd4, 5'd1, 1'b1, 5'd1, 2'd2); run_issue("lw1_flush", 0, 0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    set_instr(6'o00, 6'o41, 5'd1, 5'd1, 1'b1, 5'd2, 2'd1);
    bus.flush = 1'b0;
    run_issue("addu_after_flush", 0, 0);
    idle(3);

    // flush during a divide leaves the count running
    set_instr(6'o00, 6'o32, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0); run_issue("div_flush", 0, 0);
    bus.flush = 1'b1;
    n = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.md_busy) n++; else done = 1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
    end
    check("md_busy_through_flush", n, DIV_CYC);
    idle(2);

    // reset abandons a divide
    set_instr(6'o00, 6'o32, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0); run_issue("div_reset", 0, 0);
    idle(2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("md_busy_after_reset", {31'd0, bus.md_busy}, 32'd0);
    @(posedge clk); #1;
    set_instr(6'o00, 6'o20, 5'd0, 5'd0, 1'b1, 5'd3, 2'd1); run_issue("mfhi_after_reset", 0, 0);
    idle(2);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 11)];
      fn = (op == 6'o00) ? fns[$urandom_range(0, 13)] : 6'($urandom);
      set_instr(op, fn, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
      bus.flush = ($urandom_range(0, 24) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hzdctl.md
# hzdctl

Parametrised pipeline hazard controller for the MIPS core's Decode stage. It replaces the purely combinational stall decision with an internal scoreboard of in-flight GRF writers. Each writer carries its own decrementing Tnew down a configurable number of post-D stages. A built-in multiply/divide busy counter with separate mult and div latencies generates the M/D stall without an external `occupied` signal.

## Interface
Parameters:
- `DEPTH`, 2: number of tracked stages after D (slot 0 = E, slot 1 = M, …); range 1–4.
- `MULT_CYC`, 5: busy cycles after a mult/multu issues; range 1–31.
- `DIV_CYC`, 10: busy cycles after a div/divu issues; range 1–31.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: reset is synchronous and active-high.
- `opcode` in 6: D-stage instruction opcode.
- `funct` in 6: D-stage instruction funct.
- `rs` in 5: D-stage source register rs.
- `rt` in 5: D-stage source register rt.
- `d_wen` in 1: D instruction writes the GRF.
- `d_wreg` in 5: D instruction destination register.
- `d_tnew` in 2: Tnew the D instruction will have on entering E (load 2, ALU/mfhi/mflo 1, jal 0).
- `flush` in 1: kill all tracked slots (exception/eret).
- `stall` out 1: hold F/D and insert a bubble into E.
- `stall_cause` out 2: 0 = none, 1 = data, 2 = M/D, 3 = both.
- `md_busy` out 1: the multiply/divide unit is occupied.

## Operation
- Instruction classes, decoded from opcode/funct:
  - R-type: opcode 0.
  - jr: funct 010.
  - Branch: opcode[5:3] = 0 and opcode[2] = 1.
  - Imm: opcode[5:3] = 1.
  - Load: opcode[5:3] = 4.
  - Store: opcode[5:3] = 5.
  - MDTR: R-type with funct[5:3] = 3. mult/multu are funct 030/031; div/divu are funct 032/033.
  - MDMT: mthi (021) and mtlo (023).
  - MDMF: mfhi (020) and mflo (022).
  - syscall: funct 014.
- tUse is 0 for jr and branches, 1 for everything else.
- Slot k holds `{wen, wreg, tnew}`. `hit_src_k` = `wen_k` & `wreg_k` ≠ 0 & `wreg_k` = src & `tnew_k` > tUse.
- The data stall ORs the hits over all DEPTH slots, for the sources each class uses:
  - jr: rs only.
  - Branch: rs and rt.
  - R-type other than MDMF/MDMT/syscall: rs and rt.
  - Imm, Load, Store, MDMT: rs only.
  - All other classes: never stall.
- M/D stall is raised when `md_busy` is high and the D instruction is MDTR, MDMT or MDMF.
- `stall` = data stall | M/D stall.
- Slot update, every cycle:
  - Slot k (k ≥ 1) takes slot k−1 with tnew decremented, saturating at 0.
  - Slot 0 takes `{d_wen, d_wreg, d_tnew}` when `stall` is low and `flush` is low. Otherwise slot 0 takes a bubble (wen = 0, tnew = 0).
- `flush` zeroes all slots. It does not touch the M/D counter, because an issued operation completes.
- M/D counter, 5 bits:
  - When an MDTR issues (D not stalled, no flush), the counter loads MULT_CYC or DIV_CYC.
  - Otherwise it decrements while nonzero.
  - `md_busy` = counter ≠ 0.
  - An MDTR issued while the counter is 0 is the only load path. An MDTR arriving while busy is itself stalled.

## Timing
- `stall`, `stall_cause` and `md_busy` are combinational from D inputs and registered state. There is no added latency.
- Reset values: all slots 0, counter 0. Therefore `stall` = 0, `stall_cause` = 0, `md_busy` = 0 in the first cycle after reset.
- An MDTR that issues in cycle t makes `md_busy` high in cycles t+1 … t+N, where N = MULT_CYC or DIV_CYC.
- Reset asserted mid-operation clears the counter and slots on that edge. A pending divide is abandoned.
- When `flush` and a non-stalled issue occur together, `flush` wins and slot 0 becomes a bubble.
- When `flush` and `reset` are both high, `reset` behaviour applies.
- A writer to $0 never causes a stall.

## Structure
- Shared package `hzd_pkg` holds:
  - the opcode/funct constants listed above;
  - tUse codes;
  - `stall_cause` encodings;
  - the slot record typedef `{wen, wreg[4:0], tnew[1:0]}`.
- Sub-module `mdbusy` contains the M/D latency counter (inputs: issue, is_div, reset; output: busy). The scoreboard shift and the hit logic live in `hzdctl`.

## Test plan
- lw $1 issues, then addu $2,$1,$3 in D → `stall` = 1 for exactly 1 cycle, `stall_cause` = 1, then addu issues.
- lw $1, then beq $1,$4 (DEPTH = 2) → 2 stall cycles; alu $1 then beq $1 → 1 stall cycle; jal (d_tnew = 0) then jr $31 → 0 stall.
- mult issues at t, mflo in D at t+1 (MULT_CYC = 5) → `stall` high for t+1 … t+5, `stall_cause` = 2, mflo issues at t+6. Repeat with div and DIV_CYC = 10 → 10 stall cycles.
- lw $0, then addu $2,$0,$0 → no stall. addu $5,$6,$7 with lw $6 in slot 0 but `d_wen` = 0 recorded → no stall.
- lw $1 in slot 0 plus `flush` → next cycle, addu using $1 does not stall. Div in progress plus `flush` → `md_busy` stays high until the count expires.
- Div issues, `reset` pulsed 3 cycles later → `md_busy` = 0 on the next cycle, and mfhi in D issues without stalling.
